// File: rtl/veda_pkg.sv
// Shared opcodes, mode encodings and default widths for the Veda command front-end.
package veda_pkg;

    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned ADDR_W_DEF    = 5;
    localparam int unsigned RD_LAT_DEF    = 2;
    localparam int unsigned RSP_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_ECHO  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    localparam logic SCRIBBLE  = 1'b0;
    localparam logic INTERPRET = 1'b1;

    // Only READ and ECHO produce a response and therefore consume a credit.
    function automatic logic op_needs_credit(input logic [1:0] op);
        return (op_e'(op) == OP_READ) || (op_e'(op) == OP_ECHO);
    endfunction

endpackage

// File: rtl/veda_rsp_fifo.sv
// Synchronous response FIFO; storage resets to zero so the head reads 0 when empty after reset.
module veda_rsp_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_push,
    input  logic [DATA_W-1:0]            i_push_data,
    input  logic                         i_pop,
    output logic [DATA_W-1:0]            o_pop_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_do_push  = i_push & ~o_full;
    assign w_do_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/veda_cmd_sequencer.sv
// Command front-end for the Veda register file: decodes one command per cycle onto the
// Veda pins, tracks the fixed read latency with a tag pipe and buffers results under credit control.
module veda_cmd_sequencer
    import veda_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned RD_LAT    = RD_LAT_DEF,
    parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              err,
    output logic              mem_reset,
    output logic              mem_write_enable,
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_address_a,
    output logic [ADDR_W-1:0] mem_address_b,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int unsigned FCNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned OUT_W  = $clog2(RSP_DEPTH + RD_LAT) + 1;

    if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RSP_DEPTH must be a power of two and at least 2");
    end
    if (RD_LAT < 1) begin : g_bad_lat
        $error("RD_LAT must be at least 1");
    end

    logic [RD_LAT-1:0] r_tag;
    logic              r_err;
    logic              w_accept;
    logic              w_issue_rsp;
    logic              w_rsvd;
    logic              w_push;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [FCNT_W-1:0] w_fifo_count;
    logic [OUT_W-1:0]  w_outstanding;

    assign mem_reset = ~reset_n;

    // Credits in use: results still travelling through Veda plus results already buffered.
    always_comb begin
        w_outstanding = OUT_W'(w_fifo_count);
        for (int i = 0; i < int'(RD_LAT); i++) begin
            w_outstanding = w_outstanding + OUT_W'(r_tag[i]);
        end
    end

    // Depends on cmd_op, which the upstream holds stable while cmd_valid is high.
    assign cmd_ready = reset_n &
                       (~op_needs_credit(cmd_op) | (w_outstanding < OUT_W'(RSP_DEPTH)));
    assign w_accept  = cmd_valid & cmd_ready;

    always_comb begin
        mem_write_enable = 1'b0;
        mem_mode         = SCRIBBLE;
        mem_address_a    = '0;
        mem_address_b    = '0;
        mem_data_in      = '0;
        w_issue_rsp      = 1'b0;
        w_rsvd           = 1'b0;
        if (w_accept) begin
            case (op_e'(cmd_op))
                OP_WRITE: begin
                    mem_write_enable = 1'b1;
                    mem_address_a    = cmd_addr_a;
                    mem_data_in      = cmd_data;
                end
                OP_READ: begin
                    mem_mode      = INTERPRET;
                    mem_address_b = cmd_addr_b;
                    w_issue_rsp   = 1'b1;
                end
                OP_ECHO: begin
                    mem_data_in = cmd_data;
                    w_issue_rsp = 1'b1;
                end
                default: begin
                    w_rsvd = 1'b1;
                end
            endcase
        end
    end

    // Tag pipe mirrors the Veda read path; err is sticky until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag <= '0;
            r_err <= 1'b0;
        end else begin
            r_tag[0] <= w_issue_rsp;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            if (w_rsvd) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err    = r_err;
    assign w_push = r_tag[RD_LAT-1] & ~w_fifo_full;

    veda_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_push_data (mem_data_out),
        .i_pop       (rsp_ready),
        .o_pop_data  (rsp_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign rsp_valid = ~w_fifo_empty;

endmodule

// File: tb/tb_veda_cmd_sequencer.sv
// Bench for veda_cmd_sequencer: Veda register-file model, queue-based response scoreboard, directed tests.
module tb_veda_cmd_sequencer;
    import veda_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_addr_a = '0;
    logic [AW-1:0] cmd_addr_b = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic          err;
    logic          mem_reset;
    logic          mem_write_enable;
    logic          mem_mode;
    logic [AW-1:0] mem_address_a;
    logic [AW-1:0] mem_address_b;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int last_rsp = 0;

    veda_cmd_sequencer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_addr_a       (cmd_addr_a),
        .cmd_addr_b       (cmd_addr_b),
        .cmd_data         (cmd_data),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .err              (err),
        .mem_reset        (mem_reset),
        .mem_write_enable (mem_write_enable),
        .mem_mode         (mem_mode),
        .mem_address_a    (mem_address_a),
        .mem_address_b    (mem_address_b),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Veda model: edge-written register file, two-stage output path (interpret reads, scribble echoes data_in).
    logic [DW-1:0] veda_mem [32];
    logic [DW-1:0] v_s1, v_s2;
    always @(posedge clk or posedge mem_reset) begin
        if (mem_reset) begin
            for (int i = 0; i < 32; i++) veda_mem[i] <= '0;
            v_s1 <= '0;
            v_s2 <= '0;
        end else begin
            if (mem_write_enable) veda_mem[mem_address_a] <= mem_data_in;
            v_s1 <= mem_mode ? veda_mem[mem_address_b] : mem_data_in;
            v_s2 <= v_s1;
        end
    end
    assign mem_data_out = v_s2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected responses in command order, each visible 3 cycles after acceptance.
    typedef struct {
        logic [DW-1:0] data;
        int            acc;
    } exp_t;
    exp_t          q[$];
    logic [DW-1:0] ref_mem [32];
    logic          err_m = 1'b0;

    always @(negedge clk) begin
        logic          exp_rdy, exp_rv, acc, we_e, mode_e;
        logic [AW-1:0] aa_e, ab_e;
        logic [DW-1:0] din_e;
        exp_t          e;
        if (!reset_n) begin
            q.delete();
            for (int i = 0; i < 32; i++) ref_mem[i] = '0;
            err_m = 1'b0;
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_err", err, 0);
            chk("rst_mem_reset", mem_reset, 1);
            chk("rst_mem_ctrl", {mem_write_enable, mem_mode, mem_address_a, mem_address_b, mem_data_in}, 0);
        end else begin
            exp_rdy = (cmd_op == OP_WRITE) || (cmd_op == OP_RSVD) || (q.size() < 4);
            chk("cmd_ready", cmd_ready, exp_rdy);
            exp_rv = (q.size() > 0) && (cyc >= q[0].acc + 3);
            chk("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv && rsp_valid) chk("rsp_data", rsp_data, q[0].data);
            chk("err", err, err_m);
            chk("mem_reset", mem_reset, 0);
            acc    = cmd_valid && cmd_ready;
            we_e   = acc && (cmd_op == OP_WRITE);
            mode_e = acc && (cmd_op == OP_READ);
            aa_e   = we_e ? cmd_addr_a : '0;
            ab_e   = mode_e ? cmd_addr_b : '0;
            din_e  = (acc && (cmd_op == OP_WRITE || cmd_op == OP_ECHO)) ? cmd_data : '0;
            chk("mem_ctrl", {mem_write_enable, mem_mode, mem_address_a, mem_address_b, mem_data_in},
                {we_e, mode_e, aa_e, ab_e, din_e});
            if (rsp_valid && rsp_ready && q.size() > 0) void'(q.pop_front());
            if (acc) begin
                case (cmd_op)
                    2'b00: ref_mem[cmd_addr_a] = cmd_data;
                    2'b01: begin e.data = ref_mem[cmd_addr_b]; e.acc = cyc; q.push_back(e); end
                    2'b10: begin e.data = cmd_data; e.acc = cyc; q.push_back(e); end
                    default: err_m = 1'b1;
                endcase
            end
        end
    end

    task automatic try_send(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                            input logic [DW-1:0] d, input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_data = d;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            if (cmd_ready) begin ok = 1'b1; last_acc = cyc; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr_a = '0; cmd_addr_b = '0; cmd_data = '0;
    endtask

    task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [DW-1:0] d);
        bit ok;
        try_send(op, a, b, d, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: op %0d not accepted, got ready 0 expected 1", op);
        end
    endtask

    task automatic wait_rsp(input logic [DW-1:0] exp, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rsp_valid && rsp_ready) && n < 50);
        last_rsp = cyc;
        if (!(rsp_valid && rsp_ready)) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no response expected %h", nm, exp);
        end else begin
            chk(nm, rsp_data, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int n_acc;
        bit stalled;

        // Reset values
        repeat (3) @(negedge clk);
        chk("lit_rst_cmd_ready", cmd_ready, 0);
        chk("lit_rst_rsp_valid", rsp_valid, 0);
        chk("lit_rst_mem_reset", mem_reset, 1);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Write/read round trip
        send(OP_WRITE, 5'd3, 5'd0, 32'hDEADBEEF);
        send(OP_READ, 5'd0, 5'd3, 32'h0);
        wait_rsp(32'hDEADBEEF, "rt_data");
        chk("rt_latency", 64'(last_rsp - last_acc), 3);

        // Echo leaves Veda untouched
        send(OP_ECHO, 5'd0, 5'd0, 32'h12345678);
        wait_rsp(32'h12345678, "echo_data");
        send(OP_READ, 5'd0, 5'd0, 32'h0);
        wait_rsp(32'h0, "echo_nowrite");

        // Back-pressure: 6 reads with consumer stalled
        for (int i = 4; i < 10; i++) send(OP_WRITE, 5'(i), 5'd0, 32'hA000_0000 | 32'(i));
        rsp_ready = 1'b0;
        n_acc = 0;
        stalled = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!stalled) begin
                try_send(OP_READ, 5'd0, 5'(4 + i), 32'h0, 6, ok);
                if (ok) n_acc++;
                else stalled = 1'b1;
            end
        end
        chk("bp_accept_count", n_acc, 4);
        try_send(OP_WRITE, 5'd10, 5'd0, 32'hCAFE0010, 3, ok);
        chk("full_write_accepted", ok, 1);
        cmd_valid = 1'b1; cmd_op = OP_READ; cmd_addr_b = 5'd8;
        @(negedge clk);
        chk("full_read_blocked", cmd_ready, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr_b = '0;
        rsp_ready = 1'b1;
        wait_rsp(32'hA000_0004, "bp_rsp0");
        wait_rsp(32'hA000_0005, "bp_rsp1");
        wait_rsp(32'hA000_0006, "bp_rsp2");
        wait_rsp(32'hA000_0007, "bp_rsp3");
        send(OP_READ, 5'd0, 5'd8, 32'h0);
        wait_rsp(32'hA000_0008, "bp_rsp4");
        send(OP_READ, 5'd0, 5'd9, 32'h0);
        wait_rsp(32'hA000_0009, "bp_rsp5");
        send(OP_READ, 5'd0, 5'd10, 32'h0);
        wait_rsp(32'hCAFE0010, "full_write_data");

        // Reserved opcode
        send(OP_RSVD, 5'd11, 5'd0, 32'h0BAD0BAD);
        @(negedge clk);
        chk("rsvd_err", err, 1);
        repeat (4) @(negedge clk);
        chk("rsvd_err_sticky", err, 1);
        chk("rsvd_no_rsp", rsp_valid, 0);
        send(OP_READ, 5'd0, 5'd11, 32'h0);
        wait_rsp(32'h0, "rsvd_no_write");

        // Reset with two reads in flight
        send(OP_READ, 5'd0, 5'd3, 32'h0);
        send(OP_READ, 5'd0, 5'd4, 32'h0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        repeat (4) @(negedge clk);
        chk("rst_mid_err", err, 0);
        chk("rst_mid_no_rsp", rsp_valid, 0);
        send(OP_READ, 5'd0, 5'd3, 32'h0);
        wait_rsp(32'h0, "rst_mid_cleared");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/veda_cmd_sequencer.md
# veda_cmd_sequencer

Command front-end that drives the 32×32-bit Veda register file. It accepts a valid/ready command stream (write, read, echo), issues at most one memory operation per cycle on the Veda port set, and tracks the fixed two-cycle read path. Returned read/echo data goes through a credit-protected response FIFO onto a valid/ready response stream. The block sits directly upstream of Veda and owns its control pins.

## Interface
- `DATA_W`, default 32: data width; must match Veda.
- `ADDR_W`, default 5: address width; must match Veda.
- `RD_LAT`, default 2: cycles from issue to valid `mem_data_out`.
- `RSP_DEPTH`, default 4: response FIFO entries; power of two, ≥ 2.
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`, in, 2: 00 WRITE, 01 READ, 10 ECHO, 11 reserved.
- `cmd_addr_a`, in, ADDR_W: write address.
- `cmd_addr_b`, in, ADDR_W: read address.
- `cmd_data`, in, DATA_W: write or echo data.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_data`, out, DATA_W: read or echo result.
- `err`, out, 1: sticky; set by a reserved opcode.
- `mem_reset`, out, 1: Veda reset, active-high, equal to `~reset_n`.
- `mem_write_enable`, out, 1: to Veda `write_enable`.
- `mem_mode`, out, 1: to Veda `mode`; 0 = scribble, 1 = interpret.
- `mem_address_a`, out, ADDR_W: to Veda `address_a`.
- `mem_address_b`, out, ADDR_W: to Veda `address_b`.
- `mem_data_in`, out, DATA_W: to Veda `data_in`.
- `mem_data_out`, in, DATA_W: from Veda `data_out`.

## Operation
Issue is combinational from the accepted command in the same cycle. All `mem_*` controls except `mem_reset` are driven from this decode.
- **WRITE:** `mem_write_enable=1`, `mem_mode=0`, `address_a`/`data_in` from the command. No response.
- **READ:** `mem_write_enable=0`, `mem_mode=1`, `mem_address_b=cmd_addr_b`. One response.
- **ECHO:** `mem_write_enable=0`, `mem_mode=0`, `mem_data_in=cmd_data`. One response, returning `cmd_data`.
- **Reserved opcode:** accepted and dropped. No memory activity, no response, `err` set until reset.
- **Idle (no accept):** `mem_write_enable=0`, `mem_mode=0`, all addresses and data 0.
- **Return pipe:** an RD_LAT-deep shift register of tag bits marks which cycles return data. A tag at the tail pushes `mem_data_out` into the response FIFO on that edge.
- **Credits:** `outstanding` = tags in the pipe + FIFO occupancy.
  - `cmd_ready` is 1 when `outstanding < RSP_DEPTH`, or when the pending command is a WRITE or reserved opcode.
  - `cmd_ready` is a function of `cmd_op`. This is allowed because `cmd_op` is stable while `cmd_valid` is high.
  - The credit rule guarantees the FIFO never overflows.
- **Simultaneous push and pop:** occupancy stays unchanged.
- **Pop from a full FIFO:** frees exactly one credit, usable on the next cycle.
- **Read after write:** a READ of an address written by the preceding WRITE returns the new value. No hazard logic is needed because Veda writes on the edge.

## Timing
- A command accepted in cycle t has `mem_data_out` valid in cycle t+RD_LAT and is pushed at the end of that cycle.
- `rsp_valid` rises in cycle t+RD_LAT+1, giving a minimum command-to-response latency of 3 cycles.
- Throughput is one command per cycle while credits remain.
- Responses leave in command order. `rsp_data` holds stable while `rsp_valid & ~rsp_ready`.
- **Reset values:** `rsp_valid=0`, `rsp_data=0`, `err=0`, tag pipe empty, FIFO empty, `mem_reset=1`. `cmd_ready=0` while `reset_n` is low.
- **Reset mid-operation:** all in-flight and buffered responses are discarded. Veda is cleared in the same window.
- **After reset release:** `cmd_ready` may assert in the first cycle after `reset_n` rises. The bench holds `cmd_valid` low for 2 cycles after release so Veda's reset has fully released.

## Structure
- Package `veda_pkg`:
  - opcode constants `OP_WRITE`, `OP_READ`, `OP_ECHO`, `OP_RSVD`;
  - mode constants `SCRIBBLE=1'b0`, `INTERPRET=1'b1`;
  - default widths.
- Sub-module `veda_rsp_fifo`: synchronous FIFO with `reset_n`, push/pop, full/empty and count. The count feeds the credit logic.
- Top level holds the decode, tag pipe, credit counter and `err` flag.

## Test plan
- **Write/read round trip:** after reset, WRITE a=3 d=0xDEADBEEF, then READ b=3 → `rsp_data=0xDEADBEEF`, `rsp_valid` 3 cycles after the READ accept.
- **Echo:** ECHO d=0x12345678 → `rsp_data=0x12345678`; Veda contents unchanged (a following READ b=0 returns 0).
- **Back-pressure:** `rsp_ready=0`, issue 6 READs → exactly 4 accepted and `cmd_ready` then low. Raise `rsp_ready` → 4 ordered responses, then the remaining 2 are accepted.
- **Writes under full FIFO:** with the FIFO full, WRITE commands are still accepted. A later READ returns the written data.
- **Reserved opcode:** op=11 → accepted, `err=1` and stays 1, no response, no memory write.
- **Reset mid-operation:** pulse `reset_n` low with 2 READs in flight → no responses afterwards, `err=0`, and READ b=3 returns 0.
